ram_access_arbiter: RTL and testbench
=====================================

# ram_access_arbiter

Shares the single 16x8 program/data RAM between two requesters: the CPU memory path and the external program loader used to fill RAM before or between runs. Fixed-latency arbitration, round-robin on ties, with a registered req/ack handshake per requester. Drives the RAM chip-enable and write strobe. Raises a hold flag toward the CPU control block while the loader owns the RAM.

## Interface
- ADDR_W, default 4: RAM address width.
- DATA_W, default 8: RAM data width.
- ACCESS_CYCLES, default 2: cycles the RAM is enabled per access; legal range 1..15.

- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  last CPU read result.
- ld_req, ld_we, ld_addr, ld_wdata  in  1/1/ADDR_W/DATA_W  loader request; same meaning as cpu_*.
- ld_ack  out  1  one-cycle completion pulse.
- ld_rdata  out  DATA_W  last loader read result.
- ram_ce_n  out  1  RAM enable, active low.
- ram_we_n  out  1  RAM write strobe, active low.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data; valid while ram_ce_n=0 and ram_we_n=1.
- cpu_hold  out  1  high while the loader owns the RAM.
- busy  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE: no requester owns the RAM.
  - ACCESS: RAM cycle for the granted requester.
  - ACK: completion cycle.
- IDLE:
  - If cpu_req or ld_req is high, pick the winner and latch its we/addr/wdata into ram_addr, ram_wdata and an internal we bit.
  - Load the access counter with ACCESS_CYCLES-1, go to ACCESS.
  - Tie: the winner is the requester not granted last. The last-grant register resets to LOADER, so the CPU wins the first tie.
  - A single requester always wins.
- ACCESS:
  - ram_ce_n=0 throughout.
  - ram_we_n=0 only in the final ACCESS cycle (counter=0), and only for writes.
  - Counter decrements each cycle.
  - At counter=0: for reads, register ram_rdata into the winner's rdata. Update last-grant, go to ACK.
- ACK:
  - ram_ce_n=1, ram_we_n=1.
  - Winner's ack=1 for exactly this cycle.
  - Go to IDLE.
- Requester rules:
  - Keep req and the request fields stable from assertion until the ack cycle.
  - Drop req on the edge that samples ack. If req is still high in IDLE, that is a new request.
- The request fields are latched at grant, so later changes cannot corrupt an access in flight.
- If req drops during ACCESS, the access still completes and ack still pulses.
- The loser's req stays pending. It is granted in the IDLE cycle after ACK, and never starves: round-robin guarantees service within one foreign access.
- ram_addr and ram_wdata hold their last values outside accesses.
- Write accesses never change either rdata register.
- Reads never change the non-winner's rdata register.
- cpu_hold is set on the edge granting the loader and cleared on the edge leaving ACK.
- busy is set on the edge granting either requester and cleared on the edge leaving ACK.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE; counter 0; last-grant LOADER.
  - ram_ce_n=1, ram_we_n=1, ram_addr=0, ram_wdata=0.
  - cpu_ack=0, ld_ack=0, cpu_rdata=0, ld_rdata=0, cpu_hold=0, busy=0.
- Reset mid-access aborts the access: no ack, and the strobe is released at once.
- Every output is registered; there are no combinational paths from inputs to outputs.
- req sampled high in IDLE at edge E:
  - ACCESS occupies the cycles after edges E .. E+ACCESS_CYCLES-1.
  - ack is high in the cycle after edge E+ACCESS_CYCLES.
  - rdata is valid from that same edge.
- Back-to-back throughput: one access per ACCESS_CYCLES+2 cycles.
- ram_addr and ram_wdata are stable for the whole ACCESS window, including the cycle where ram_we_n=0.

## Test plan
- Reset then idle: all outputs hold their reset values; no ram_ce_n pulse over 20 cycles with both reqs low.
- Loader write then CPU read:
  - Loader: ld_we=1, ld_addr=4'h3, ld_wdata=8'hA5. Expect ram_we_n low for exactly 1 cycle with addr 3 and data A5; ld_ack 3 cycles after the grant edge (ACCESS_CYCLES=2); cpu_hold high throughout.
  - CPU then reads addr 3: expect cpu_rdata=8'hA5, ld_rdata unchanged.
- Simultaneous reqs after reset: CPU served first and loader second, no idle gap beyond IDLE. Repeat the tie: loader served first.
- Continuous reqs from both for 8 accesses: grants alternate CPU/LD; each ack is a single cycle; no ack is lost.
- rst_n low in the ACCESS cycle of a write: ram_ce_n and ram_we_n go high immediately; no ack; the RAM model shows no write.
- ACCESS_CYCLES=1 and ACCESS_CYCLES=4 builds: ack latency is 2 and 5 cycles; ram_we_n=0 only in the last ACCESS cycle.

Source files
------------

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: shares one RAM between the CPU path and the loader.
// Ports: cpu_*/ld_* req-ack requesters, ram_* RAM pins, cpu_hold, busy.
module ram_access_arbiter #(
    parameter int ADDR_W        = 4,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ram_ce_n,
    output logic              ram_we_n,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              cpu_hold,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } state_t;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_INIT =
        CNT_W'(ACCESS_CYCLES - 1);
    // With a single access cycle the strobe must fire on the grant edge.
    localparam bit SINGLE = (ACCESS_CYCLES == 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              last_ld;
    logic              win_ld;
    logic              we_q;

    logic              grant_ld;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Loader wins if alone, or on a tie when the CPU was granted last.
    assign grant_ld  = ld_req & (~cpu_req | ~last_ld);
    assign sel_we    = grant_ld ? ld_we    : cpu_we;
    assign sel_addr  = grant_ld ? ld_addr  : cpu_addr;
    assign sel_wdata = grant_ld ? ld_wdata : cpu_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            last_ld   <= 1'b1;
            win_ld    <= 1'b0;
            we_q      <= 1'b0;
            ram_ce_n  <= 1'b1;
            ram_we_n  <= 1'b1;
            ram_addr  <= '0;
            ram_wdata <= '0;
            cpu_ack   <= 1'b0;
            ld_ack    <= 1'b0;
            cpu_rdata <= '0;
            ld_rdata  <= '0;
            cpu_hold  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            ld_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req || ld_req) begin
                        state     <= ACCESS;
                        cnt       <= CNT_INIT;
                        win_ld    <= grant_ld;
                        we_q      <= sel_we;
                        ram_addr  <= sel_addr;
                        ram_wdata <= sel_wdata;
                        ram_ce_n  <= 1'b0;
                        ram_we_n  <= ~(SINGLE & sel_we);
                        busy      <= 1'b1;
                        cpu_hold  <= grant_ld;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state    <= ACK;
                        ram_ce_n <= 1'b1;
                        ram_we_n <= 1'b1;
                        last_ld  <= win_ld;
                        if (!we_q) begin
                            if (win_ld) ld_rdata  <= ram_rdata;
                            else        cpu_rdata <= ram_rdata;
                        end
                        if (win_ld) ld_ack  <= 1'b1;
                        else        cpu_ack <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                        // Strobe only in the final access cycle.
                        if (cnt == CNT_W'(1)) ram_we_n <= ~we_q;
                    end
                end
                ACK: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    cpu_hold <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: directed vectors and corner sequences.
// Drives a 2-cycle arbiter plus 1- and 4-cycle builds for latency.
module tb_ram_access_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cpu_req, cpu_we, ld_req, ld_we;
    logic [3:0] cpu_addr, ld_addr, ram_addr;
    logic [7:0] cpu_wdata, ld_wdata, ram_wdata, ram_rdata;
    logic [7:0] cpu_rdata, ld_rdata;
    logic       cpu_ack, ld_ack, ram_ce_n, ram_we_n;
    logic       cpu_hold, busy;

    logic [7:0] mem [16] = '{default: 8'h00};

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr];
    always @(posedge clk)
        if (!ram_ce_n && !ram_we_n) mem[ram_addr] <= ram_wdata;

    ram_access_arbiter #(
        .ADDR_W(4), .DATA_W(8), .ACCESS_CYCLES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_we(ld_we),
        .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ack(ld_ack), .ld_rdata(ld_rdata),
        .ram_ce_n(ram_ce_n), .ram_we_n(ram_we_n),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .cpu_hold(cpu_hold), .busy(busy)
    );

    // Extra builds: index 0 has ACCESS_CYCLES=1, index 1 has 4.
    logic       x_req [2];
    logic       x_ack [2], x_we_n [2], x_ce [2];
    logic       x_lack [2], x_hold [2], x_busy [2];
    logic [7:0] x_crd [2], x_lrd [2], x_wd [2];
    logic [3:0] x_ad [2];
    logic       z1;
    logic [3:0] z4, x_addr;
    logic [7:0] z8, x_wdata, x_rd;

    for (genvar g = 0; g < 2; g++) begin : g_x
        ram_access_arbiter #(
            .ADDR_W(4), .DATA_W(8),
            .ACCESS_CYCLES(g == 0 ? 1 : 4)
        ) dx (
            .clk(clk), .rst_n(rst_n),
            .cpu_req(x_req[g]), .cpu_we(1'b1),
            .cpu_addr(x_addr), .cpu_wdata(x_wdata),
            .cpu_ack(x_ack[g]), .cpu_rdata(x_crd[g]),
            .ld_req(z1), .ld_we(z1),
            .ld_addr(z4), .ld_wdata(z8),
            .ld_ack(x_lack[g]), .ld_rdata(x_lrd[g]),
            .ram_ce_n(x_ce[g]), .ram_we_n(x_we_n[g]),
            .ram_addr(x_ad[g]), .ram_wdata(x_wd[g]),
            .ram_rdata(x_rd),
            .cpu_hold(x_hold[g]), .busy(x_busy[g])
        );
    end

    typedef struct {
        logic       ld;
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_c;
        logic [7:0] exp_l;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    task automatic txn(input vec_t v, output int lat,
                       output int wec, output bit ok);
        @(negedge clk);
        if (v.ld) begin
            ld_req = 1'b1; ld_we = v.we;
            ld_addr = v.addr; ld_wdata = v.wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = v.we;
            cpu_addr = v.addr; cpu_wdata = v.wdata;
        end
        lat = 0; wec = 0; ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                cpu_addr = ~v.addr; ld_addr = ~v.addr;
                cpu_wdata = ~v.wdata; ld_wdata = ~v.wdata;
            end
            if (!ram_we_n) begin
                wec++;
                if (ram_addr !== v.addr) ok = 1'b0;
                if (ram_wdata !== v.wdata) ok = 1'b0;
            end
            if (cpu_hold !== v.ld) ok = 1'b0;
            if (busy !== 1'b1) ok = 1'b0;
            if (v.ld ? cpu_ack : ld_ack) ok = 1'b0;
            if (v.ld ? ld_ack : cpu_ack) begin
                if (ram_ce_n !== 1'b1) ok = 1'b0;
                break;
            end
            if (ram_ce_n !== 1'b0) ok = 1'b0;
            if (ram_addr !== v.addr) ok = 1'b0;
        end
        cpu_req = 1'b0; ld_req = 1'b0;
    endtask

    task automatic tie(input logic [3:0] ca, input logic [3:0] la,
                       output int first, output int gap,
                       output int n);
        int t0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = ca;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = la;
        first = -1; gap = -1; n = 0; t0 = 0;
        for (int i = 0; i < 40 && n < 2; i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                if (n == 0) first = 0; else gap = i - t0;
                t0 = i; n++; cpu_req = 1'b0;
            end
            if (ld_ack) begin
                if (n == 0) first = 1; else gap = i - t0;
                t0 = i; n++; ld_req = 1'b0;
            end
        end
        cpu_req = 1'b0; ld_req = 1'b0;
    endtask

    initial begin
        int  lat, wec, first, gap, n, prev, last_i, acks, wpos;
        bit  ok, alt_ok, w_ok, ce_seen;
        vecs[0] = '{1'b1, 1'b1, 4'h3, 8'hA5, 8'h00, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 4'h3, 8'h00, 8'hA5, 8'h00};
        vecs[2] = '{1'b0, 1'b1, 4'h7, 8'h3C, 8'hA5, 8'h00};
        vecs[3] = '{1'b1, 1'b0, 4'h7, 8'h00, 8'hA5, 8'h3C};
        vecs[4] = '{1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'h3C};
        vecs[5] = '{1'b1, 1'b1, 4'hF, 8'h99, 8'h00, 8'h3C};
        vecs[6] = '{1'b0, 1'b0, 4'hF, 8'h00, 8'h99, 8'h3C};

        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
        x_req[0] = 0; x_req[1] = 0;
        x_addr = 4'h2; x_wdata = 8'h11; x_rd = 8'h5A;
        z1 = 0; z4 = 0; z8 = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        ce_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!ram_ce_n || !ram_we_n || busy) ce_seen = 1'b1;
        end
        chk("idle_no_ce", ce_seen, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wdata", ram_wdata, 0);
        chk("rst_acks", {cpu_ack, ld_ack}, 0);
        chk("rst_rdata", {cpu_rdata, ld_rdata}, 0);
        chk("rst_hold", cpu_hold, 0);

        tie(4'h3, 4'h7, first, gap, n);
        chk("tie1_first", first, 0);
        chk("tie1_gap", gap, 4);
        chk("tie1_n", n, 2);

        foreach (vecs[k]) begin
            txn(vecs[k], lat, wec, ok);
            chk($sformatf("v%0d_lat", k), lat, 3);
            chk($sformatf("v%0d_we", k), wec,
                vecs[k].we ? 1 : 0);
            chk($sformatf("v%0d_cyc", k), ok, 1);
            chk($sformatf("v%0d_crd", k), cpu_rdata,
                vecs[k].exp_c);
            chk($sformatf("v%0d_lrd", k), ld_rdata,
                vecs[k].exp_l);
            if (vecs[k].we)
                chk($sformatf("v%0d_mem", k),
                    mem[vecs[k].addr], vecs[k].wdata);
        end

        tie(4'h7, 4'h3, first, gap, n);
        chk("tie2_first", first, 1);
        chk("tie2_gap", gap, 4);
        chk("tie2_crd", cpu_rdata, 8'h3C);
        chk("tie2_lrd", ld_rdata, 8'hA5);

        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 4'h0;
        ld_req = 1; ld_we = 0; ld_addr = 4'h0;
        prev = -1; last_i = -10; n = 0; first = -1;
        alt_ok = 1; w_ok = 1;
        for (int i = 0; i < 100 && n < 8; i++) begin
            @(negedge clk);
            if (cpu_ack && ld_ack) alt_ok = 0;
            if (cpu_ack || ld_ack) begin
                if (last_i == i - 1) w_ok = 0;
                if (prev == (ld_ack ? 1 : 0)) alt_ok = 0;
                prev = ld_ack ? 1 : 0;
                if (n == 0) first = prev;
                last_i = i; n++;
            end
            if (n == 8) begin cpu_req = 0; ld_req = 0; end
        end
        cpu_req = 0; ld_req = 0;
        chk("cont_n", n, 8);
        chk("cont_first", first, 1);
        chk("cont_alt", alt_ok, 1);
        chk("cont_width", w_ok, 1);
        repeat (3) @(negedge clk);
        chk("cont_idle", busy, 0);

        @(negedge clk);
        cpu_req = 1; cpu_we = 1;
        cpu_addr = 4'h5; cpu_wdata = 8'h77;
        repeat (2) @(negedge clk);
        chk("abort_pre_we", ram_we_n, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_ce", ram_ce_n, 1);
        chk("abort_we", ram_we_n, 1);
        chk("abort_busy", busy, 0);
        cpu_req = 0;
        acks = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cpu_ack || ld_ack) acks++;
        end
        chk("abort_noack", acks, 0);
        chk("abort_nowrite", mem[5], 0);

        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            x_req[k] = 1'b1;
            lat = 0; wec = 0; wpos = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                lat++;
                if (!x_we_n[k]) begin wec++; wpos = lat; end
                if (x_ack[k]) break;
            end
            x_req[k] = 1'b0;
            chk($sformatf("x%0d_lat", k), lat, k ? 5 : 2);
            chk($sformatf("x%0d_wec", k), wec, 1);
            chk($sformatf("x%0d_wpos", k), wpos, k ? 4 : 1);
            @(negedge clk);
            chk($sformatf("x%0d_idle", k),
                {x_busy[k], x_ce[k], x_hold[k], x_lack[k]},
                4'b0100);
            chk($sformatf("x%0d_hold_bus", k),
                {x_ad[k], x_wd[k]}, {4'h2, 8'h11});
            chk($sformatf("x%0d_rd", k),
                {x_crd[k], x_lrd[k]}, 0);
        end

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
